axi_core_mux: RTL
=================

// Module: axi_core_mux
// PURPOSE
//   N-to-1 AXI4 master multiplexer. Merges the AXI master ports of NM crospaxi cores into one
//   downstream AXI master for the shared memory/peripheral fabric. AW and AR use independent
//   round-robin arbiters. Each downstream ID is the upstream ID prefixed with the core index.
//   W beats follow AW grant order; B and R responses are routed back by ID prefix.
// PARAMETERS
//   NM    2   number of upstream cores (>=2)
//   IDW   8   upstream ID width
//   OSTD  4   depth of W-order FIFO (max AW accepted ahead of their last W beat)
//   SW    $clog2(NM)  core-index width (derived, localparam)
// PORTS
//   clk        in   1            clock
//   rst        in   1            synchronous reset, active-high
//   s_awvalid/s_awready, s_wvalid/s_wready, s_arvalid/s_arready
//              in/out [NM]       upstream request handshakes
//   s_awid/s_arid                in   [NM][IDW]  upstream request IDs
//   s_awaddr/s_araddr            in   [NM][64]   addresses
//   s_awlen/s_arlen              in   [NM][8]    burst lengths
//   s_awsize/s_arsize            in   [NM][3]    beat sizes
//   s_awburst/s_arburst          in   [NM][2]    burst types
//   s_wdata    in   [NM][64]     write data
//   s_wstrb    in   [NM][8]      write strobes
//   s_wlast    in   [NM]         last write beat
//   s_bvalid/s_bready, s_rvalid/s_rready
//              out/in [NM]       upstream response handshakes
//   s_bid/s_rid                  out  [NM][IDW]  response IDs, prefix stripped
//   s_bresp/s_rresp              out  [NM][2]    response codes
//   s_rdata    out  [NM][64]     read data
//   s_rlast    out  [NM]         last read beat
//   m_aw*/m_w*/m_b*/m_ar*/m_r*   same fields, single port; m_awid/m_arid/m_bid/m_rid are IDW+SW wide
//   dbg_err    out  1            sticky: response carried an out-of-range core index
// BEHAVIOUR
//   Reset: pointers=0, locks clear, FIFO empty, dbg_err=0. All m_*valid and s_*valid outputs are 0.
//   AW arbiter:
//   - Search starts at aw_ptr and grants the first asserted s_awvalid.
//   - The grant is combinational while unlocked. aw_lock is set when m_awvalid=1 and m_awready=0,
//     and holds the grant stable until the handshake (AXI stability rule).
//   - On handshake: aw_ptr <= grant+1 (mod NM), aw_lock cleared, grant index pushed to the W-FIFO.
//   - m_awid = {grant[SW-1:0], s_awid[grant]}. Other fields pass through unchanged.
//   - s_awready[g] = m_awready only for the granted core; 0 for all others.
//   - W-FIFO full: m_awvalid=0 and all s_awready=0. No push-while-pop bypass on full.
//   AR arbiter: same scheme with its own ar_ptr/ar_lock. No FIFO and no stall condition.
//   W routing:
//   - FIFO empty: m_wvalid=0 and every s_wready=0.
//   - Otherwise head h selects the core: m_w* = s_w*[h], s_wready[h] = m_wready, all other s_wready=0.
//   - Pop on m_wvalid & m_wready & m_wlast.
//   - The FIFO is registered, so a W beat can pass no earlier than the cycle after its AW handshake.
//   - W beats issued before their AW are held. This does not deadlock because AW never waits on W.
//   B/R routing:
//   - c = m_bid[IDW+SW-1:IDW]. s_bvalid[c] = m_bvalid, s_bid[c] = m_bid[IDW-1:0], m_bready = s_bready[c].
//   - R is routed the same way using m_rid. R bursts are never interleaved by this block.
//   - c >= NM (only possible when NM is not a power of 2): m_bready/m_rready=1, the beat is dropped,
//     and dbg_err is set until reset.
//   Simultaneous FIFO push and pop in one cycle (not full) is legal; count is unchanged.
//   Pointers wrap NM-1 -> 0.
//   Reset mid-burst aborts all state. The downstream fabric is reset on the same rst.
// TESTING
//   1 NM=2, both cores raise AWVALID in cycle 0, m_awready=1 -> core0 granted (awid=0x005 -> m_awid=0x005),
//     then core1 next cycle (m_awid=0x105); aw_ptr returns to 0.
//   2 core1 AW len=3 accepted, then core0 AW len=0 -> W beats forward in order: 4 core1 beats, then
//     1 core0 beat; core0 s_wready stays 0 until core1 wlast.
//   3 m_awready held 0 for 3 cycles while core1 drops AWVALID and re-asserts -> grant stays locked
//     on the originally granted core; m_awaddr is stable.
//   4 OSTD=4 AWs accepted with no W -> fifth AW stalls (s_awready=0); one wlast handshake -> the stall
//     lifts the next cycle.
//   5 m_rid=0x1A3, rvalid, s_rready[1]=0 -> s_rvalid[1]=1, s_rid[1]=0xA3, m_rready=0;
//     with NM=3, m_bid=0x3xx -> dropped, dbg_err=1.
//   6 rst asserted mid W burst -> next cycle FIFO empty, all valids 0, pointers 0.

Source files
------------

// File: rtl/axi_core_mux.sv
`default_nettype none
// ============================================================================
// Module : axi_core_mux
// N-to-1 AXI4 master mux: round-robin AW/AR, AW-ordered W, ID-prefixed routing.
// Rev    : 1.0  initial release
// ============================================================================
module axi_core_mux #(
    parameter int NM   = 2,
    parameter int IDW  = 8,
    parameter int OSTD = 4,
    localparam int SW  = $clog2(NM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NM-1:0]             s_awvalid,
    output logic [NM-1:0]             s_awready,
    input  logic [NM-1:0][IDW-1:0]    s_awid,
    input  logic [NM-1:0][63:0]       s_awaddr,
    input  logic [NM-1:0][7:0]        s_awlen,
    input  logic [NM-1:0][2:0]        s_awsize,
    input  logic [NM-1:0][1:0]        s_awburst,
    input  logic [NM-1:0]             s_wvalid,
    output logic [NM-1:0]             s_wready,
    input  logic [NM-1:0][63:0]       s_wdata,
    input  logic [NM-1:0][7:0]        s_wstrb,
    input  logic [NM-1:0]             s_wlast,
    output logic [NM-1:0]             s_bvalid,
    input  logic [NM-1:0]             s_bready,
    output logic [NM-1:0][IDW-1:0]    s_bid,
    output logic [NM-1:0][1:0]        s_bresp,
    input  logic [NM-1:0]             s_arvalid,
    output logic [NM-1:0]             s_arready,
    input  logic [NM-1:0][IDW-1:0]    s_arid,
    input  logic [NM-1:0][63:0]       s_araddr,
    input  logic [NM-1:0][7:0]        s_arlen,
    input  logic [NM-1:0][2:0]        s_arsize,
    input  logic [NM-1:0][1:0]        s_arburst,
    output logic [NM-1:0]             s_rvalid,
    input  logic [NM-1:0]             s_rready,
    output logic [NM-1:0][IDW-1:0]    s_rid,
    output logic [NM-1:0][1:0]        s_rresp,
    output logic [NM-1:0][63:0]       s_rdata,
    output logic [NM-1:0]             s_rlast,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [IDW+SW-1:0]         m_awid,
    output logic [63:0]               m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [63:0]               m_wdata,
    output logic [7:0]                m_wstrb,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [IDW+SW-1:0]         m_bid,
    input  logic [1:0]                m_bresp,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [IDW+SW-1:0]         m_arid,
    output logic [63:0]               m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [IDW+SW-1:0]         m_rid,
    input  logic [1:0]                m_rresp,
    input  logic [63:0]               m_rdata,
    input  logic                      m_rlast,
    output logic                      dbg_err
);

    localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
    localparam int CW = $clog2(OSTD + 1);

    // First requester at or after ptr, wrapping at NM.
    function automatic logic [SW-1:0] f_rr_pick(input logic [NM-1:0] req, input logic [SW-1:0] ptr);
        logic [SW-1:0] pick;
        int idx;
        pick = ptr;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NM) idx = idx - NM;
            if (req[idx[SW-1:0]]) pick = idx[SW-1:0];
        end
        return pick;
    endfunction

    function automatic logic [SW-1:0] f_core_inc(input logic [SW-1:0] g);
        return (int'(g) == NM - 1) ? '0 : g + 1'b1;
    endfunction

    function automatic logic [PW-1:0] f_fifo_inc(input logic [PW-1:0] p);
        return (int'(p) == OSTD - 1) ? '0 : p + 1'b1;
    endfunction

    logic [SW-1:0] r_aw_ptr, r_aw_gnt, w_aw_gnt;
    logic [SW-1:0] r_ar_ptr, r_ar_gnt, w_ar_gnt;
    logic          r_aw_lock, r_ar_lock, w_aw_hs, w_ar_hs;
    logic [SW-1:0] r_fifo [OSTD];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full, w_empty, w_pop;
    logic [SW-1:0] w_head;
    logic          w_b_hit, w_r_hit;

    // ---------------- AW arbiter ----------------
    assign w_aw_gnt  = r_aw_lock ? r_aw_gnt : f_rr_pick(s_awvalid, r_aw_ptr);
    assign m_awvalid = s_awvalid[w_aw_gnt] & ~w_full;
    assign w_aw_hs   = m_awvalid & m_awready;
    assign m_awid    = {w_aw_gnt, s_awid[w_aw_gnt]};
    assign m_awaddr  = s_awaddr[w_aw_gnt];
    assign m_awlen   = s_awlen[w_aw_gnt];
    assign m_awsize  = s_awsize[w_aw_gnt];
    assign m_awburst = s_awburst[w_aw_gnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_ptr  <= '0;
            r_aw_gnt  <= '0;
            r_aw_lock <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_ptr  <= f_core_inc(w_aw_gnt);
            r_aw_lock <= 1'b0;
        end else if (m_awvalid) begin
            r_aw_gnt  <= w_aw_gnt;
            r_aw_lock <= 1'b1;
        end
    end

    // ---------------- AR arbiter ----------------
    assign w_ar_gnt  = r_ar_lock ? r_ar_gnt : f_rr_pick(s_arvalid, r_ar_ptr);
    assign m_arvalid = s_arvalid[w_ar_gnt];
    assign w_ar_hs   = m_arvalid & m_arready;
    assign m_arid    = {w_ar_gnt, s_arid[w_ar_gnt]};
    assign m_araddr  = s_araddr[w_ar_gnt];
    assign m_arlen   = s_arlen[w_ar_gnt];
    assign m_arsize  = s_arsize[w_ar_gnt];
    assign m_arburst = s_arburst[w_ar_gnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar_ptr  <= '0;
            r_ar_gnt  <= '0;
            r_ar_lock <= 1'b0;
        end else if (w_ar_hs) begin
            r_ar_ptr  <= f_core_inc(w_ar_gnt);
            r_ar_lock <= 1'b0;
        end else if (m_arvalid) begin
            r_ar_gnt  <= w_ar_gnt;
            r_ar_lock <= 1'b1;
        end
    end

    // ---------------- W-order FIFO ----------------
    assign w_full  = (r_cnt == CW'(OSTD));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rp];

    always_ff @(posedge clk) begin
        if (w_aw_hs) r_fifo[r_wp] <= w_aw_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_aw_hs) r_wp <= f_fifo_inc(r_wp);
            if (w_pop)   r_rp <= f_fifo_inc(r_rp);
            if (w_aw_hs && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_aw_hs && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // ---------------- W routing ----------------
    assign m_wvalid = ~w_empty & s_wvalid[w_head];
    assign m_wdata  = s_wdata[w_head];
    assign m_wstrb  = s_wstrb[w_head];
    assign m_wlast  = s_wlast[w_head];
    assign w_pop    = m_wvalid & m_wready & m_wlast;

    always_comb begin
        s_awready = '0;
        s_arready = '0;
        s_wready  = '0;
        for (int g = 0; g < NM; g++) begin
            s_awready[g] = (int'(w_aw_gnt) == g) & m_awready & ~w_full;
            s_arready[g] = (int'(w_ar_gnt) == g) & m_arready;
            s_wready[g]  = (int'(w_head) == g) & m_wready & ~w_empty;
        end
    end

    // ---------------- B/R routing by ID prefix ----------------
    always_comb begin
        s_bvalid = '0;
        s_rvalid = '0;
        m_bready = 1'b1;
        m_rready = 1'b1;
        w_b_hit  = 1'b0;
        w_r_hit  = 1'b0;
        for (int g = 0; g < NM; g++) begin
            s_bid[g]   = m_bid[IDW-1:0];
            s_bresp[g] = m_bresp;
            s_rid[g]   = m_rid[IDW-1:0];
            s_rresp[g] = m_rresp;
            s_rdata[g] = m_rdata;
            s_rlast[g] = m_rlast;
            if (int'(m_bid[IDW+SW-1:IDW]) == g) begin
                w_b_hit     = 1'b1;
                s_bvalid[g] = m_bvalid;
                m_bready    = s_bready[g];
            end
            if (int'(m_rid[IDW+SW-1:IDW]) == g) begin
                w_r_hit     = 1'b1;
                s_rvalid[g] = m_rvalid;
                m_rready    = s_rready[g];
            end
        end
    end

    // Unmatched prefixes are sunk (ready=1 above) and flagged until reset.
    always_ff @(posedge clk) begin
        if (rst)
            dbg_err <= 1'b0;
        else if ((m_bvalid && !w_b_hit) || (m_rvalid && !w_r_hit))
            dbg_err <= 1'b1;
    end

endmodule
`default_nettype wire
